pixel_readout_fsm: RTL and testbench

Frame sequencer and readout stage for the pixel array. It drives the array's erase, expose, convert and row-read controls and the 8-bit ADC count bus. It then captures one row of column data at a time and streams the pixels out one per beat over a valid/ready interface. It sits between the array and the downstream frame buffer or serial link.

---
 rtl/pixel_readout_fsm.sv | 159 +++++++++++++++
 tb/tb_pixel_readout_fsm.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_fsm.sv
// Pixel array frame sequencer: erase/expose/convert control, then row capture
// and per-pixel streaming over a valid/ready port.
module pixel_readout_fsm #(
  parameter int H_PIXELS  = 2,
  parameter int V_PIXELS  = 2,
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic [7:0]            cnt_data,
  output logic                  cnt_oe,
  output logic [V_PIXELS-1:0]   read,
  input  logic [H_PIXELS*8-1:0] pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col,
  output logic                  out_last,
  output logic                  frame_done
);

  localparam int CMAX_EE = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int CMAX    = (CMAX_EE > C_CONVERT) ? CMAX_EE : C_CONVERT;
  localparam int CW      = $clog2(CMAX + 2);
  localparam int RW      = $clog2(V_PIXELS + 1);
  localparam int HW      = $clog2(H_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_RSETTLE,
    S_RCAPTURE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] col_q, col_d;
  logic [7:0]    rowbuf_q [H_PIXELS];
  logic [7:0]    rowbuf_d [H_PIXELS];

  logic last_col, last_row, rd_en;

  assign last_col = (col_q == HW'(H_PIXELS - 1));
  assign last_row = (row_q == RW'(V_PIXELS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int c = 0; c < H_PIXELS; c++) rowbuf_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      for (int c = 0; c < H_PIXELS; c++) rowbuf_q[c] <= rowbuf_d[c];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    for (int c = 0; c < H_PIXELS; c++) rowbuf_d[c] = rowbuf_q[c];
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        if (cnt_q == CW'(C_ERASE - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == CW'(C_EXPOSE - 1)) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        // the counter doubles as the ramp value on the count bus
        if (cnt_q == CW'(C_CONVERT)) begin
          state_d = S_RSETTLE;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSETTLE: state_d = S_RCAPTURE;
      S_RCAPTURE: begin
        for (int c = 0; c < H_PIXELS; c++)
          rowbuf_d[c] = pix_data[8*c +: 8];
        col_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (out_ready) begin
          if (!last_col) begin
            col_d = col_q + 1'b1;
          end else if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_RSETTLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en = (state_q == S_RSETTLE) || (state_q == S_RCAPTURE);

  always_comb begin
    busy       = (state_q != S_IDLE);
    erase      = (state_q == S_ERASE);
    expose     = (state_q == S_EXPOSE);
    convert    = (state_q == S_CONVERT);
    cnt_oe     = convert;
    cnt_data   = convert ? 8'(cnt_q) : 8'h00;
    out_valid  = (state_q == S_STREAM);
    frame_done = (state_q == S_DONE);
    for (int r = 0; r < V_PIXELS; r++)
      read[r] = rd_en && (row_q == RW'(r));
    out_data = 8'h00;
    for (int c = 0; c < H_PIXELS; c++)
      if (out_valid && (col_q == HW'(c))) out_data = rowbuf_q[c];
    out_row  = out_valid ? 8'(row_q) : 8'h00;
    out_col  = out_valid ? 8'(col_q) : 8'h00;
    out_last = out_valid && last_row && last_col;
  end

endmodule

// File: tb/tb_pixel_readout_fsm.sv
// Directed bench for pixel_readout_fsm: default 2x2 instance and a 4x3
// instance with short phases, observed through a shared monitor mux.
module tb_pixel_readout_fsm;

  logic clk = 1'b0;
  logic reset, start, out_ready, sel;
  always #5 clk = ~clk;

  logic        a_busy, a_erase, a_expose, a_convert, a_cnt_oe;
  logic [7:0]  a_cnt_data, a_out_data, a_out_row, a_out_col;
  logic [1:0]  a_read;
  logic [15:0] a_pix;
  logic        a_out_valid, a_out_last, a_frame_done, a_start;

  logic        b_busy, b_erase, b_expose, b_convert, b_cnt_oe;
  logic [7:0]  b_cnt_data, b_out_data, b_out_row, b_out_col;
  logic [2:0]  b_read;
  logic [31:0] b_pix;
  logic        b_out_valid, b_out_last, b_frame_done, b_start;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  pixel_readout_fsm u_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
    .erase(a_erase), .expose(a_expose), .convert(a_convert),
    .cnt_data(a_cnt_data), .cnt_oe(a_cnt_oe), .read(a_read),
    .pix_data(a_pix), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_row(a_out_row), .out_col(a_out_col),
    .out_last(a_out_last), .frame_done(a_frame_done)
  );

  pixel_readout_fsm #(
    .H_PIXELS(4), .V_PIXELS(3), .C_ERASE(1), .C_EXPOSE(1), .C_CONVERT(3)
  ) u_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
    .erase(b_erase), .expose(b_expose), .convert(b_convert),
    .cnt_data(b_cnt_data), .cnt_oe(b_cnt_oe), .read(b_read),
    .pix_data(b_pix), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_row(b_out_row), .out_col(b_out_col),
    .out_last(b_out_last), .frame_done(b_frame_done)
  );

  always_comb begin
    unique case (a_read)
      2'b01:   a_pix = 16'hA53C;
      2'b10:   a_pix = 16'h11FF;
      default: a_pix = 16'h0000;
    endcase
  end

  always_comb begin
    b_pix = '0;
    for (int r = 0; r < 3; r++)
      if (b_read[r])
        for (int c = 0; c < 4; c++)
          b_pix[8*c +: 8] = 8'(64 + 16*r + c);
  end

  logic       m_busy, m_erase, m_expose, m_convert, m_cnt_oe;
  logic [7:0] m_cnt_data, m_out_data, m_out_row, m_out_col;
  logic [2:0] m_read;
  logic       m_out_valid, m_out_last, m_frame_done;

  always_comb begin
    m_busy       = sel ? b_busy       : a_busy;
    m_erase      = sel ? b_erase      : a_erase;
    m_expose     = sel ? b_expose     : a_expose;
    m_convert    = sel ? b_convert    : a_convert;
    m_cnt_oe     = sel ? b_cnt_oe     : a_cnt_oe;
    m_cnt_data   = sel ? b_cnt_data   : a_cnt_data;
    m_read       = sel ? b_read       : {1'b0, a_read};
    m_out_valid  = sel ? b_out_valid  : a_out_valid;
    m_out_data   = sel ? b_out_data   : a_out_data;
    m_out_row    = sel ? b_out_row    : a_out_row;
    m_out_col    = sel ? b_out_col    : a_out_col;
    m_out_last   = sel ? b_out_last   : a_out_last;
    m_frame_done = sel ? b_frame_done : a_frame_done;
  end

  logic [46:0] a_all;
  logic [47:0] b_all;
  assign a_all = {a_busy, a_erase, a_expose, a_convert, a_cnt_oe, a_cnt_data,
                  a_read, a_out_valid, a_out_data, a_out_row, a_out_col,
                  a_out_last, a_frame_done};
  assign b_all = {b_busy, b_erase, b_expose, b_convert, b_cnt_oe, b_cnt_data,
                  b_read, b_out_valid, b_out_data, b_out_row, b_out_col,
                  b_out_last, b_frame_done};

  int checks = 0;
  int failures = 0;

  int n_erase, n_expose, n_conv, n_busy, n_done, n_beats;
  int n_read [3];
  int cnt_err, overlap_err, rd_stream_err, stall_err, stall_cnt;
  int max_cnt, first_cnt;
  bit timeout;
  logic [24:0] beats [32];
  logic [24:0] hold_v;

  task automatic run_frame(input int stall_beat, input int stall_len,
                           input bit noise, input bit hold_start);
    bit seen, held;
    int ones;
    n_erase = 0; n_expose = 0; n_conv = 0; n_busy = 0; n_done = 0;
    n_beats = 0; cnt_err = 0; overlap_err = 0; rd_stream_err = 0;
    stall_err = 0; stall_cnt = 0; max_cnt = -1; first_cnt = -1;
    timeout = 1'b0; seen = 1'b0; held = 1'b0;
    for (int r = 0; r < 3; r++) n_read[r] = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 3000) begin
        timeout = 1'b1;
        break;
      end
      if (m_busy) seen = 1'b1;
      else if (seen) break;
      start = 1'b0;
      if (noise && (m_expose || m_out_valid)) start = cyc[0];
      if (hold_start && (m_frame_done || held)) begin
        held = 1'b1;
        start = 1'b1;
      end
      if (m_busy) n_busy++;
      if (m_erase) n_erase++;
      if (m_expose) n_expose++;
      if (m_frame_done) n_done++;
      for (int r = 0; r < 3; r++) if (m_read[r]) n_read[r]++;
      if (m_cnt_oe !== m_convert) cnt_err++;
      if (m_convert) begin
        if (n_conv == 0) first_cnt = int'(m_cnt_data);
        if (m_cnt_data !== 8'(n_conv)) cnt_err++;
        max_cnt = int'(m_cnt_data);
        n_conv++;
      end else if (m_cnt_data !== 8'h00) begin
        cnt_err++;
      end
      ones = int'(m_erase) + int'(m_expose) + int'(m_convert) +
             int'(m_read != 3'b000) + int'(m_out_valid) + int'(m_frame_done);
      if (ones > 1 || $countones(m_read) > 1) overlap_err++;
      if (m_out_valid && m_read != 3'b000) rd_stream_err++;
      out_ready = 1'b1;
      if (m_out_valid && n_beats == stall_beat) begin
        if (stall_cnt == 0)
          hold_v = {m_out_row, m_out_col, m_out_data, m_out_last};
        else if (hold_v !== {m_out_row, m_out_col, m_out_data, m_out_last})
          stall_err++;
        if (stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
        end
      end
      if (m_out_valid && out_ready) begin
        if (n_beats < 32)
          beats[n_beats] = {m_out_row, m_out_col, m_out_data, m_out_last};
        n_beats++;
      end
    end
  endtask

  task automatic check_a_beats(input string tag);
    logic [7:0] exp_d [4];
    logic [24:0] exp_b;
    exp_d[0] = 8'h3C; exp_d[1] = 8'hA5; exp_d[2] = 8'hFF; exp_d[3] = 8'h11;
    checks++;
    if (n_beats !== 4) begin
      failures++;
      $display("FAIL %s_beat_count got=%0d exp=4", tag, n_beats);
    end
    for (int i = 0; i < 4; i++) begin
      exp_b = {8'(i / 2), 8'(i % 2), exp_d[i], 1'(i == 3)};
      checks++;
      if (beats[i] !== exp_b) begin
        failures++;
        $display("FAIL %s_beat%0d got=%h exp=%h", tag, i, beats[i], exp_b);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_all !== '0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", a_all);
    end
    checks++;
    if (b_all !== '0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", b_all);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_convert();
    bit found = 1'b0;
    sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_convert && a_cnt_data == 8'd40) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midconv_reach got=0 exp=1");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (a_all !== '0) begin
      failures++;
      $display("FAIL midconv_reset got=%h exp=0", a_all);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    run_frame(-1, 0, 1'b0, 1'b0);
    checks++;
    if (timeout) begin
      failures++; $display("FAIL full_timeout got=1 exp=0");
    end
    checks++;
    if ({n_erase, n_expose, n_conv} !== {32'd5, 32'd255, 32'd256}) begin
      failures++;
      $display("FAIL full_phases got=%0d/%0d/%0d exp=5/255/256",
               n_erase, n_expose, n_conv);
    end
    checks++;
    if (cnt_err !== 0 || first_cnt !== 0 || max_cnt !== 255) begin
      failures++;
      $display("FAIL full_cnt errs=%0d first=%0d max=%0d exp=0/0/255",
               cnt_err, first_cnt, max_cnt);
    end
    checks++;
    if ({n_read[0], n_read[1], n_read[2]} !== {32'd2, 32'd2, 32'd0}) begin
      failures++;
      $display("FAIL full_read got=%0d/%0d/%0d exp=2/2/0",
               n_read[0], n_read[1], n_read[2]);
    end
    checks++;
    if (overlap_err !== 0 || rd_stream_err !== 0) begin
      failures++;
      $display("FAIL full_overlap got=%0d/%0d exp=0/0",
               overlap_err, rd_stream_err);
    end
    checks++;
    if (n_done !== 1 || n_busy !== 525) begin
      failures++;
      $display("FAIL full_len done=%0d busy=%0d exp=1/525", n_done, n_busy);
    end
    check_a_beats("full");
  endtask

  task automatic test_stall();
    sel = 1'b0;
    run_frame(1, 10, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 10 || stall_err !== 0) begin
      failures++;
      $display("FAIL stall_hold cnt=%0d errs=%0d exp=10/0",
               stall_cnt, stall_err);
    end
    checks++;
    if (rd_stream_err !== 0 || n_busy !== 535 || timeout) begin
      failures++;
      $display("FAIL stall_len rd=%0d busy=%0d exp=0/535",
               rd_stream_err, n_busy);
    end
    check_a_beats("stall");
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    run_frame(-1, 0, 1'b1, 1'b1);
    checks++;
    if (n_erase !== 5 || n_busy !== 525 || n_done !== 1 || timeout) begin
      failures++;
      $display("FAIL noise_len erase=%0d busy=%0d done=%0d exp=5/525/1",
               n_erase, n_busy, n_done);
    end
    check_a_beats("noise");
    @(negedge clk);
    checks++;
    if ({a_erase, a_busy} !== 2'b11) begin
      failures++;
      $display("FAIL held_restart got=%b exp=11", {a_erase, a_busy});
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small();
    logic [24:0] exp_b;
    sel = 1'b1;
    run_frame(-1, 0, 1'b0, 1'b0);
    checks++;
    if ({n_erase, n_expose, n_conv} !== {32'd1, 32'd1, 32'd4} || timeout) begin
      failures++;
      $display("FAIL small_phases got=%0d/%0d/%0d exp=1/1/4",
               n_erase, n_expose, n_conv);
    end
    checks++;
    if (cnt_err !== 0 || first_cnt !== 0 || max_cnt !== 3) begin
      failures++;
      $display("FAIL small_cnt errs=%0d first=%0d max=%0d exp=0/0/3",
               cnt_err, first_cnt, max_cnt);
    end
    checks++;
    if ({n_read[0], n_read[1], n_read[2]} !== {32'd2, 32'd2, 32'd2} ||
        overlap_err !== 0) begin
      failures++;
      $display("FAIL small_read got=%0d/%0d/%0d ovl=%0d exp=2/2/2/0",
               n_read[0], n_read[1], n_read[2], overlap_err);
    end
    checks++;
    if (n_busy !== 25 || n_beats !== 12) begin
      failures++;
      $display("FAIL small_len busy=%0d beats=%0d exp=25/12",
               n_busy, n_beats);
    end
    for (int i = 0; i < 12; i++) begin
      exp_b = {8'(i / 4), 8'(i % 4), 8'(64 + 16*(i / 4) + (i % 4)),
               1'(i == 11)};
      checks++;
      if (beats[i] !== exp_b) begin
        failures++;
        $display("FAIL small_beat%0d got=%h exp=%h", i, beats[i], exp_b);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
    test_reset();
    test_reset_mid_convert();
    test_full_frame();
    test_stall();
    test_start_ignored();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
